// File: rtl/ad9643_spi_master.sv
// AD9643 3-wire SPI initiator: one register command becomes one 24-bit MSB-first frame.
// Optional AD9643_SPI_VERIFY_EN: each write is followed by an automatic readback frame.
module ad9643_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int CSB_SETUP = 2,
  parameter int CSB_HOLD  = 2,
  parameter int IDLE_MIN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        sclk,
  output logic        csb,
  output logic        sdio_o,
  output logic        sdio_oe,
  input  logic        sdio_i,
  output logic [2:0]  dbg_state_o
);

  // Command handshake: a transfer happens on the cycle cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so requests while busy are simply not taken.
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic        phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] sr_q, sr_d;
  logic [7:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        sclk_q, sclk_d, csb_q, csb_d, sdio_q, sdio_d, oe_q, oe_d;
  logic        accept, in_frame_d;

`ifdef AD9643_SPI_VERIFY_EN
  logic [12:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rb_q, rb_d, chk_q, chk_d, err_q, err_d;
`endif

  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state_q != S_IDLE) || accept;
  assign sclk        = sclk_q;
  assign csb         = csb_q;
  assign sdio_o      = sdio_q;
  assign sdio_oe     = oe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
`ifdef AD9643_SPI_VERIFY_EN
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rb_d    = rb_q;
    chk_d   = chk_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_SETUP;
        cnt_d   = '0;
        rw_d    = cmd_rw;
        sr_d    = {cmd_rw, 2'b00, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata};
`ifdef AD9643_SPI_VERIFY_EN
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        rb_d    = !cmd_rw;
        chk_d   = 1'b0;
`endif
      end
      S_SETUP: begin
        if (cnt_q == 16'(CSB_SETUP - 1)) begin
          state_d = S_SHIFT;
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SHIFT: begin
        // Data bits are sampled in the first clk of each sclk-high phase.
        if (phase_q && (div_q == '0) && (bit_q >= 5'd16)) rd_d = {rd_q[6:0], sdio_i};
        if (div_q == 16'(CLK_DIV - 1)) begin
          div_d   = '0;
          phase_d = !phase_q;
          if (phase_q) begin
            if (bit_q == 5'd23) begin
              state_d = S_HOLD;
              cnt_d   = '0;
            end else begin
              bit_d = bit_q + 5'd1;
              sr_d  = {sr_q[22:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 16'(CSB_HOLD - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
`ifdef AD9643_SPI_VERIFY_EN
          // A write reports only after its readback frame completes.
          if (rw_q) begin
            rsp_valid_d = 1'b1;
            rdata_d     = rd_q;
            err_d       = chk_q && (rd_q != wdata_q);
            chk_d       = 1'b0;
          end
`else
          rsp_valid_d = 1'b1;
          if (rw_q) rdata_d = rd_q;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 16'(IDLE_MIN - 1)) begin
          state_d = S_IDLE;
`ifdef AD9643_SPI_VERIFY_EN
          if (rb_q) begin
            state_d = S_SETUP;
            cnt_d   = '0;
            rw_d    = 1'b1;
            sr_d    = {1'b1, 2'b00, addr_q, 8'h00};
            rb_d    = 1'b0;
            chk_d   = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values are registered from next-state so sclk/csb never glitch.
    in_frame_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
    csb_d      = !in_frame_d;
    sclk_d     = (state_d == S_SHIFT) && phase_d;
    sdio_d     = in_frame_d && sr_d[23];
    oe_d       = in_frame_d && (!rw_d || (state_d == S_SETUP) ||
                                ((state_d == S_SHIFT) && (bit_d < 5'd16)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      sr_q        <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      sclk_q      <= 1'b0;
      csb_q       <= 1'b1;
      sdio_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      sclk_q      <= sclk_d;
      csb_q       <= csb_d;
      sdio_q      <= sdio_d;
      oe_q        <= oe_d;
    end
  end

`ifdef AD9643_SPI_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rb_q    <= 1'b0;
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rb_q    <= rb_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ad9643_spi_master.sv
// Scoreboard bench for ad9643_spi_master: default-timing instance plus a CLK_DIV=1 instance.
module tb_ad9643_spi_master;

  localparam int T_RSP = 197;
`ifdef AD9643_SPI_VERIFY_EN
  localparam int T_WR_RSP  = 397;
  localparam int T_WR_NEXT = 401;
`else
  localparam int T_WR_RSP  = 197;
  localparam int T_WR_NEXT = 201;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (defaults) ----------------
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0, sdio_i = 1'b0;
  logic [12:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err, busy, sclk, csb, sdio_o, sdio_oe;
  logic [7:0]  rsp_rdata;
  logic [2:0]  dbg_state;

  ad9643_spi_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .sclk(sclk), .csb(csb), .sdio_o(sdio_o), .sdio_oe(sdio_oe),
    .sdio_i(sdio_i), .dbg_state_o(dbg_state)
  );

  // ---------------- DUT (fast timing) ----------------
  logic        f_cmd_valid = 1'b0, f_cmd_rw = 1'b0, f_sdio_i = 1'b0;
  logic [12:0] f_cmd_addr = '0;
  logic [7:0]  f_cmd_wdata = '0;
  logic        f_cmd_ready, f_rsp_valid, f_rsp_err, f_busy, f_sclk, f_csb, f_sdio_o, f_sdio_oe;
  logic [7:0]  f_rsp_rdata;
  logic [2:0]  f_dbg_state;

  ad9643_spi_master #(.CLK_DIV(1), .CSB_SETUP(1), .CSB_HOLD(1), .IDLE_MIN(4)) dut_fast (
    .clk(clk), .rst(rst), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_rw(f_cmd_rw),
    .cmd_addr(f_cmd_addr), .cmd_wdata(f_cmd_wdata), .rsp_valid(f_rsp_valid),
    .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err), .busy(f_busy), .sclk(f_sclk), .csb(f_csb),
    .sdio_o(f_sdio_o), .sdio_oe(f_sdio_oe), .sdio_i(f_sdio_i), .dbg_state_o(f_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [47:0] exp_q[$];     // {rsp cycle, 7'b0, err, rdata}
  logic [23:0] mosi_q[$];    // expected frames on the default instance
  logic [23:0] f_mosi_q[$];  // expected frames on the fast instance
  logic [7:0]  resp_byte = 8'h00;
  logic [7:0]  last_rd = 8'h00;
  int          rsp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- responder + monitor (default instance) ----------------
  logic        prev_sclk = 1'b0, prev_csb = 1'b1, frame_rw = 1'b0, have_prev = 1'b0;
  logic [23:0] mosi = '0;
  int          rises = 0, falls = 0, low_cnt = 0, high_cnt = 0, oe_bad = 0, idle_bad = 0;

  always @(negedge clk) begin
    logic [47:0] e;
    logic [23:0] em;
    if (rst) begin
      rises = 0; falls = 0; low_cnt = 0; high_cnt = 0; oe_bad = 0; mosi = '0;
      have_prev = 1'b0; prev_sclk = 1'b0; prev_csb = 1'b1; sdio_i = 1'b0;
    end else begin
      if (rsp_valid) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: got rsp_valid at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", 32'(cyc), e[47:16]);
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e[7:0]));
          chk("rsp_err", 32'(rsp_err), 32'(e[8]));
        end
      end
      if (!csb) begin
        if (prev_csb) begin
          if (have_prev) chk("csb_gap_ge_idle_min", 32'(high_cnt >= 4), 32'd1);
          rises = 0; falls = 0; low_cnt = 0; oe_bad = 0; mosi = '0;
          frame_rw = (mosi_q.size() > 0) ? mosi_q[0][23] : 1'b0;
        end
        low_cnt++;
        if (sclk && !prev_sclk) begin
          rises++;
          mosi = {mosi[22:0], sdio_o};
        end
        if (!sclk && prev_sclk) begin
          falls++;
          sdio_i = (frame_rw && falls >= 16 && falls <= 23) ? resp_byte[23 - falls] : 1'b0;
        end
        if (sdio_oe !== (!frame_rw || falls < 16)) oe_bad++;
      end else begin
        if (!prev_csb) begin
          if (mosi_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_unexpected: got frame 0x%06h, expected none", mosi);
          end else begin
            em = mosi_q.pop_front();
            if (em[23]) chk("mosi_instr", 32'(mosi[23:8]), 32'(em[23:8]));
            else        chk("mosi_frame", 32'(mosi), 32'(em));
            chk("sclk_rises", 32'(rises), 32'd24);
            chk("csb_low_cycles", 32'(low_cnt), 32'd196);
            chk("sdio_oe_profile_bad_cycles", 32'(oe_bad), 32'd0);
          end
          have_prev = 1'b1;
          high_cnt = 0;
          sdio_i = 1'b0;
        end
        high_cnt++;
        if (sdio_oe || sclk) idle_bad++;
      end
      prev_sclk = sclk;
      prev_csb = csb;
    end
  end

  // ---------------- monitor (fast instance) ----------------
  logic        f_prev_sclk = 1'b0, f_prev_csb = 1'b1;
  logic [23:0] f_mosi = '0;
  int          f_rises = 0, f_low = 0, f_last_rise = 0, f_per_bad = 0;

  always @(negedge clk) begin
    logic [23:0] em;
    if (rst) begin
      f_prev_sclk = 1'b0; f_prev_csb = 1'b1; f_rises = 0; f_low = 0; f_per_bad = 0;
    end else begin
      if (!f_csb) begin
        if (f_prev_csb) begin
          f_rises = 0; f_low = 0; f_mosi = '0; f_per_bad = 0;
        end
        f_low++;
        if (f_sclk && !f_prev_sclk) begin
          if (f_rises > 0 && (cyc - f_last_rise) != 2) f_per_bad++;
          f_last_rise = cyc;
          f_rises++;
          f_mosi = {f_mosi[22:0], f_sdio_o};
        end
      end else if (!f_prev_csb) begin
        if (f_mosi_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fast_frame_unexpected: got frame 0x%06h, expected none", f_mosi);
        end else begin
          em = f_mosi_q.pop_front();
          if (em[23]) chk("fast_mosi_instr", 32'(f_mosi[23:8]), 32'(em[23:8]));
          else        chk("fast_mosi_frame", 32'(f_mosi), 32'(em));
          chk("fast_sclk_rises", 32'(f_rises), 32'd24);
          chk("fast_csb_low_cycles", 32'(f_low), 32'd50);
          chk("fast_sclk_period_bad", 32'(f_per_bad), 32'd0);
        end
      end
      f_prev_sclk = f_sclk;
      f_prev_csb = f_csb;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic rw, input logic [12:0] a, input logic [7:0] d,
                      input logic [7:0] rb, input logic keep, output int t_acc);
    int n;
    n = 0;
    t_acc = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no cmd_ready within %0d cycles, expected accept", n);
      cmd_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    resp_byte = rb;
    mosi_q.push_back({rw, 2'b00, a, rw ? 8'h00 : d});
    if (rw) begin
      last_rd = rb;
      exp_q.push_back({32'(t_acc + T_RSP), 7'd0, 1'b0, rb});
    end else begin
`ifdef AD9643_SPI_VERIFY_EN
      mosi_q.push_back({1'b1, 2'b00, a, 8'h00});
      last_rd = rb;
      exp_q.push_back({32'(t_acc + T_WR_RSP), 7'd0, rb != d, rb});
`else
      exp_q.push_back({32'(t_acc + T_WR_RSP), 7'd0, 1'b0, last_rd});
`endif
    end
    @(negedge clk);
    cmd_valid = keep; cmd_rw = ~rw; cmd_addr = ~a; cmd_wdata = ~d;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < limit);
    chk("idle_reached", 32'(cmd_ready), 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int t1, t2, n, snap;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_csb", 32'(csb), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_sdio_oe", 32'(sdio_oe), 32'd0);
    chk("rst_sdio_o", 32'(sdio_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // Single write, then single read with 0x82 from the responder.
    send(1'b0, 13'h014, 8'h01, 8'h01, 1'b0, t1);
    chk("busy_in_frame", 32'(busy), 32'd1);
    chk("ready_low_in_frame", 32'(cmd_ready), 32'd0);
    chk("csb_low_after_accept", 32'(csb), 32'd0);
    wait_idle(1000);
    send(1'b1, 13'h001, 8'h00, 8'h82, 1'b0, t1);
    wait_idle(1000);

    // Back-to-back with cmd_valid held; inputs scrambled right after first accept.
    send(1'b0, 13'h0FF, 8'h5A, 8'h5A, 1'b1, t1);
    send(1'b1, 13'h123, 8'h00, 8'h3C, 1'b0, t2);
    chk("b2b_accept_spacing", 32'(t2 - t1), 32'(T_WR_NEXT));
    wait_idle(1000);
    send(1'b0, 13'h1FFF, 8'hE7, 8'hE7, 1'b0, t1);
    wait_idle(1000);

    // Abort a write during the 10th sclk-high phase.
    send(1'b0, 13'h0AA, 8'h55, 8'h00, 1'b0, t1);
    n = 0;
    while (!(sclk && rises == 10) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reached_10th_high_phase", 32'(sclk && rises == 10), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_csb", 32'(csb), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_sdio_oe", 32'(sdio_oe), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    exp_q.delete();
    mosi_q.delete();
    snap = rsp_cnt;
    last_rd = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("no_rsp_after_abort", 32'(rsp_cnt), 32'(snap));
    chk("rdata_cleared_by_reset", 32'(rsp_rdata), 32'd0);
    send(1'b0, 13'h014, 8'hA5, 8'hA5, 1'b0, t1);
    wait_idle(1000);

    // Fast-timing instance: one write.
    @(negedge clk);
    f_cmd_valid = 1'b1; f_cmd_rw = 1'b0; f_cmd_addr = 13'h1ABC; f_cmd_wdata = 8'hC3;
    n = 0;
    while (!f_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fast_accept", 32'(f_cmd_ready), 32'd1);
    f_mosi_q.push_back({1'b0, 2'b00, 13'h1ABC, 8'hC3});
`ifdef AD9643_SPI_VERIFY_EN
    f_mosi_q.push_back({1'b1, 2'b00, 13'h1ABC, 8'h00});
`endif
    @(negedge clk);
    f_cmd_valid = 1'b0; f_cmd_addr = 13'h0000; f_cmd_wdata = 8'h00;

`ifdef AD9643_SPI_VERIFY_EN
    // Readback matches, then mismatches.
    send(1'b0, 13'h005, 8'h03, 8'h03, 1'b0, t1);
    wait_idle(1000);
    send(1'b0, 13'h005, 8'h03, 8'h02, 1'b0, t1);
    wait_idle(1000);
`endif

    n = 0;
    while ((exp_q.size() != 0 || mosi_q.size() != 0 || f_mosi_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("mosi_q_drained", 32'(mosi_q.size()), 32'd0);
    chk("fast_mosi_q_drained", 32'(f_mosi_q.size()), 32'd0);
    chk("idle_pins_bad_cycles", 32'(idle_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
